mem_wb_skid_stage: RTL and testbench

Parametrised, elastic successor to the fixed MEM/WB pipeline register in the pipelined CPU. It carries write-back control, the destination register and NUM_DATA data words from the MEM stage to the WB stage. It uses a valid/ready handshake backed by a 2-entry skid buffer, so in_ready has no combinational path from out_ready. It adds synchronous flush, a qualified register-write strobe and a saturating stall counter.

---
 rtl/mem_wb_skid_stage.sv | 131 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer.
// The main register drives the outputs. The skid register catches one entry
// that arrives while the output is back-pressured. in_ready is decoded from
// the registered state only, so it has no combinational path from out_ready.
// Also provides a synchronous flush, a qualified register-file write strobe
// and a saturating count of back-pressured cycles.
module mem_wb_skid_stage #(
  parameter int CTRL_W    = 3,
  parameter int REGWR_BIT = 0,
  parameter int RD_W      = 5,
  parameter int DATA_W    = 32,
  parameter int NUM_DATA  = 3,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [RD_W-1:0]            out_rd,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic                       out_regwr,
  output logic [1:0]                 occupancy,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int DW    = NUM_DATA * DATA_W;
  localparam int PAY_W = CTRL_W + RD_W + DW;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAY_W-1:0]   main_q, main_d;
  logic [PAY_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [PAY_W-1:0]   in_pay;
  logic               accept;
  logic               release_w;

  // Payload layout: {ctrl, rd, data words}
  assign in_pay    = {in_ctrl, in_rd, in_data};

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);

  assign out_ctrl  = main_q[PAY_W-1 -: CTRL_W];
  assign out_rd    = main_q[DW +: RD_W];
  assign out_data  = main_q[DW-1:0];
  assign stall_cnt = stall_q;

  // Bubbles and writes to r0 never reach the register file
  assign out_regwr = out_valid & out_ctrl[REGWR_BIT] & (out_rd != '0);

  assign accept    = in_valid & in_ready;
  assign release_w = out_valid & out_ready;

  // Next-state and payload steering; flush overrides every transition
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_pay;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && release_w) begin
            main_d = in_pay;
          end else if (release_w) begin
            state_d = EMPTY;
          end else if (accept) begin
            skid_d  = in_pay;
            state_d = FULL;
          end
        end
        FULL: begin
          if (release_w) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Back-pressure counter saturates rather than wrapping; flush leaves it alone
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State and storage registers, cleared immediately when reset is asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage. A FIFO scoreboard of capacity two
// receives every accepted entry; each cycle the head of the queue is compared
// with the DUT outputs, together with handshake, occupancy and stall counter.
module tb_mem_wb_skid_stage;

  localparam int CNT_W     = 4;
  localparam int STALL_MAX = 15;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [95:0] data;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [4:0]  in_rd;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic [95:0] out_data;
  logic        out_regwr;
  logic [1:0]  occupancy;
  logic [CNT_W-1:0] stall_cnt;

  mem_wb_skid_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .out_regwr (out_regwr),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests;
  int     fails;
  entry_t exp_q[$];
  int     stall_m;
  bit     zero_m;
  bit     last_acc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    entry_t h;
    chk("in_ready",  128'(in_ready),  128'(exp_q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    chk("occupancy", 128'(occupancy), 128'(exp_q.size()));
    chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_ctrl",  128'(out_ctrl),  128'(h.ctrl));
      chk("out_rd",    128'(out_rd),    128'(h.rd));
      chk("out_data",  128'(out_data),  128'(h.data));
      chk("out_regwr", 128'(out_regwr), 128'(h.ctrl[0] && (h.rd != 5'd0)));
    end else begin
      chk("out_regwr_idle", 128'(out_regwr), 128'(0));
      if (zero_m) begin
        chk("zero_ctrl", 128'(out_ctrl), 128'(0));
        chk("zero_rd",   128'(out_rd),   128'(0));
        chk("zero_data", 128'(out_data), 128'(0));
      end
    end
  endtask

  // Check the current cycle, then advance the scoreboard across one rising edge
  task automatic cycle();
    bit     acc;
    bit     rel;
    bit     fl;
    entry_t e;
    check_all();
    acc = in_valid && (exp_q.size() < 2);
    rel = (exp_q.size() > 0) && out_ready;
    fl  = flush;
    e   = '{ctrl: in_ctrl, rd: in_rd, data: in_data};
    if ((exp_q.size() > 0) && !out_ready && (stall_m < STALL_MAX)) stall_m++;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      zero_m = 1'b1;
    end else begin
      if (rel) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(e);
        zero_m = 1'b0;
      end
    end
    last_acc = acc && !fl;
    #1;
  endtask

  task automatic set_in(input logic [2:0] c, input logic [4:0] r, input logic [31:0] w0);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_rd    = r;
    in_data  = {w0 + 32'd4, w0 ^ 32'hA5A5_0000, w0};
  endtask

  task automatic wait_acc();
    int n;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 50) begin
      cycle();
      n++;
    end
    chk("accept_timeout", 128'(last_acc), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [4:0] r, input logic [31:0] w0);
    set_in(c, r, w0);
    wait_acc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    stall_m   = 0;
    zero_m    = 1'b1;
    last_acc  = 1'b0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_rd     = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: streaming with out_ready=1, one entry per cycle
    for (int i = 0; i < 4; i++) begin
      set_in(3'b001, 5'(i + 1), 32'h10 + 32'(i));
      cycle();
      chk("stream_accept", 128'(last_acc), 128'(1));
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // 2: back-pressure fills main then skid, C waits upstream
    out_ready = 1'b0;
    send(3'b001, 5'd10, 32'hA0);
    send(3'b001, 5'd11, 32'hB0);
    set_in(3'b001, 5'd12, 32'hC0);
    cycle();
    cycle();
    chk("full_in_ready", 128'(in_ready), 128'(0));
    chk("full_occ",      128'(occupancy), 128'(2));
    chk("stall_three",   128'(stall_cnt), 128'(3));
    out_ready = 1'b1;
    wait_acc();
    cycle();
    cycle();

    // 3: write to r0 and a non-writing entry are suppressed
    send(3'b001, 5'd0, 32'h300);
    chk("r0_valid", 128'(out_valid), 128'(1));
    chk("r0_regwr", 128'(out_regwr), 128'(0));
    send(3'b110, 5'd7, 32'h301);
    chk("nowr_regwr", 128'(out_regwr), 128'(0));
    cycle();
    chk("idle_regwr", 128'(out_regwr), 128'(0));

    // 4: flush from FULL with a concurrent input
    out_ready = 1'b0;
    send(3'b011, 5'd20, 32'h400);
    send(3'b101, 5'd21, 32'h401);
    set_in(3'b001, 5'd22, 32'h402);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_data",  128'(out_data),  128'(0));
    chk("flush_ready", 128'(in_ready),  128'(1));
    chk("flush_stall", 128'(stall_cnt), 128'(5));
    out_ready = 1'b1;
    cycle();
    cycle();

    // 6: asynchronous reset between edges while FULL
    out_ready = 1'b0;
    send(3'b001, 5'd30, 32'h600);
    send(3'b001, 5'd31, 32'h601);
    #3;
    rst = 1'b0;
    #1;
    exp_q.delete();
    stall_m = 0;
    zero_m  = 1'b1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_occ",   128'(occupancy), 128'(0));
    check_all();
    @(posedge clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    send(3'b001, 5'd9, 32'h700);
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk("post_rst_rd",    128'(out_rd),    128'(9));
    cycle();

    // 5: stall counter saturates at 2^CNT_W-1
    out_ready = 1'b0;
    send(3'b001, 5'd5, 32'h500);
    for (int i = 0; i < 20; i++) cycle();
    chk("stall_sat", 128'(stall_cnt), 128'(15));
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("stall_hold", 128'(stall_cnt), 128'(15));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
